// File: rtl/wb_shift_ctrl_if.sv
// Bus and engine-handshake bundle for the LED sweep controller.
interface wb_shift_ctrl_if;
    logic        i_wb_cyc;
    logic        i_wb_stb;
    logic        i_wb_we;
    logic [1:0]  i_wb_addr;
    logic [31:0] i_wb_data;
    logic        o_wb_ack;
    logic        o_wb_stall;
    logic [31:0] o_wb_data;
    logic        o_request;
    logic        i_busy;
    logic        o_irq;

    // Controller side
    modport slave (
        input  i_wb_cyc,
        input  i_wb_stb,
        input  i_wb_we,
        input  i_wb_addr,
        input  i_wb_data,
        output o_wb_ack,
        output o_wb_stall,
        output o_wb_data,
        output o_request,
        input  i_busy,
        output o_irq
    );

    // Bus master plus shift engine side
    modport master (
        output i_wb_cyc,
        output i_wb_stb,
        output i_wb_we,
        output i_wb_addr,
        output i_wb_data,
        input  o_wb_ack,
        input  o_wb_stall,
        input  o_wb_data,
        input  o_request,
        output i_busy,
        input  o_irq
    );
endinterface

// File: rtl/wb_shift_ctrl.sv
// Wishbone-controlled sweep sequencer: queues sweep requests for an LED
// shift engine, tracks completions and timeouts, and interrupts on drain.
module wb_shift_ctrl #(
    parameter int unsigned PEND_W        = 8,
    parameter int unsigned START_TIMEOUT = 4
) (
    input  logic           i_clk,
    input  logic           i_reset_n,
    wb_shift_ctrl_if.slave bus
);

    localparam int unsigned TMO_W   = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
    localparam int unsigned DONE_W  = 16;
    localparam int unsigned DATA_W  = 32;
    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_DONE   = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_REQ        = 2'd1,
        S_WAIT_START = 2'd2,
        S_WAIT_DONE  = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [PEND_W-1:0]   pend_q;
    logic [PEND_W-1:0]   pend_d;
    logic [PEND_W-1:0]   pend_dec;
    logic [PEND_W:0]     pend_add;
    logic [DONE_W-1:0]   done_q;
    logic                err_q;
    logic                live_q;
    logic [TMO_W-1:0]    tmo_q;
    logic [TMO_W-1:0]    tmo_d;
    logic                sweep_done;
    logic                timeout;
    logic                xfer;
    logic                rd_req;
    logic                ctrl_wr;
    logic                stat_wr;
    logic                done_wr;
    logic [DATA_W-1:0]   status;
    logic [DATA_W-1:0]   rdata_d;
    logic                ack_q;
    logic                req_q;
    logic                irq_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                unused_data;

    // Upper write-data bits carry no meaning for any register
    assign unused_data = ^bus.i_wb_data[DATA_W-1:9];

    // Bus decode; strobes in the first cycle out of reset are not accepted
    always_comb begin
        xfer    = live_q & bus.i_wb_cyc & bus.i_wb_stb;
        rd_req  = xfer & ~bus.i_wb_we;
        ctrl_wr = xfer & bus.i_wb_we & (bus.i_wb_addr == A_CTRL);
        stat_wr = xfer & bus.i_wb_we & (bus.i_wb_addr == A_STATUS);
        done_wr = xfer & bus.i_wb_we & (bus.i_wb_addr == A_DONE);
    end

    // State register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if ((pend_q != '0) && !bus.i_busy) state_d = S_REQ;
            end
            S_REQ: begin
                state_d = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (bus.i_busy)   state_d = S_WAIT_DONE;
                else if (timeout) state_d = S_IDLE;
            end
            S_WAIT_DONE: begin
                if (!bus.i_busy) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: start-timeout counting, sweep completion and timeout events
    always_comb begin
        tmo_d      = '0;
        sweep_done = 1'b0;
        timeout    = 1'b0;
        unique case (state_q)
            S_WAIT_START: begin
                if (!bus.i_busy) begin
                    if (tmo_q == TMO_W'(START_TIMEOUT - 1)) timeout = 1'b1;
                    else                                   tmo_d   = tmo_q + TMO_W'(1);
                end
            end
            S_WAIT_DONE: begin
                sweep_done = ~bus.i_busy;
            end
            default: ;
        endcase
    end

    // Pending count: non-underflowing decrement first, then clear or saturating add
    always_comb begin
        pend_dec = pend_q;
        if ((sweep_done || timeout) && (pend_q != '0)) pend_dec = pend_q - PEND_W'(1);
        pend_add = {1'b0, pend_dec} + {1'b0, bus.i_wb_data[PEND_W-1:0]};
        pend_d   = pend_dec;
        if (ctrl_wr) begin
            if (bus.i_wb_data[8])        pend_d = '0;
            else if (pend_add[PEND_W])   pend_d = '1;
            else                         pend_d = pend_add[PEND_W-1:0];
        end
    end

    // Read mux from the pre-edge register view
    always_comb begin
        status                = '0;
        status[31]            = err_q;
        status[30]            = bus.i_busy;
        status[17:16]         = 2'(state_q);
        status[PEND_W-1:0]    = pend_q;
        rdata_d               = '0;
        unique case (bus.i_wb_addr)
            A_STATUS: rdata_d = status;
            A_DONE:   rdata_d = {{(DATA_W - DONE_W){1'b0}}, done_q};
            default:  rdata_d = '0;
        endcase
    end

    // Control/status registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pend_q <= '0;
            done_q <= '0;
            err_q  <= 1'b0;
            tmo_q  <= '0;
            live_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            tmo_q  <= tmo_d;
            live_q <= 1'b1;
            if (done_wr)         done_q <= '0;
            else if (sweep_done) done_q <= done_q + DONE_W'(1);
            if (timeout)         err_q  <= 1'b1;
            else if (stat_wr)    err_q  <= 1'b0;
        end
    end

    // Registered bus and engine outputs
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
            req_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            ack_q   <= xfer;
            rdata_q <= rd_req ? rdata_d : '0;
            req_q   <= (state_d == S_REQ);
            irq_q   <= sweep_done & (pend_d == '0);
        end
    end

    assign bus.o_wb_ack   = ack_q;
    assign bus.o_wb_stall = 1'b0;
    assign bus.o_wb_data  = rdata_q;
    assign bus.o_request  = req_q;
    assign bus.o_irq      = irq_q;

endmodule

// File: tb/tb_wb_shift_ctrl.sv
// Bench for wb_shift_ctrl: directed scenarios plus random bus traffic,
// all checked against a sweep-level reference model.
module tb_wb_shift_ctrl;

    logic i_clk     = 1'b0;
    logic i_reset_n = 1'b0;

    wb_shift_ctrl_if bus();

    wb_shift_ctrl #(
        .PEND_W        (8),
        .START_TIMEOUT (4)
    ) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .bus       (bus)
    );

    always #5 i_clk = ~i_clk;

    int n_chk  = 0;
    int n_fail = 0;
    int n_req  = 0;
    int n_irq  = 0;

    // Reference model state: sweep-level view of the controller
    int         m_pend  = 0;
    int         m_done  = 0;
    bit         m_err   = 0;
    bit         m_live  = 0;
    bit         m_on    = 0;
    int         m_age   = 0;
    bit         m_seen  = 0;
    int         m_wait  = 0;
    bit         exp_ack = 0;
    bit         exp_req = 0;
    bit         exp_irq = 0;
    logic [31:0] exp_data = '0;

    // Engine model knobs
    bit eng_dead      = 0;
    int eng_hold      = 4;
    int eng_fix_delay = 0;
    int eng_delay     = 0;
    int eng_len       = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic tick();
        @(negedge i_clk);
        #1;
    endtask

    task automatic bus_xfer(input bit we, input logic [1:0] a, input logic [31:0] d,
                            output logic [31:0] rdata);
        bus.i_wb_cyc  = 1'b1;
        bus.i_wb_stb  = 1'b1;
        bus.i_wb_we   = we;
        bus.i_wb_addr = a;
        bus.i_wb_data = d;
        tick();
        rdata         = bus.o_wb_data;
        bus.i_wb_cyc  = 1'b0;
        bus.i_wb_stb  = 1'b0;
        bus.i_wb_we   = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        bus_xfer(1'b1, a, d, dummy);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus_xfer(1'b0, a, 32'd0, d);
    endtask

    function automatic bit quiet();
        return !m_on && (m_pend == 0) && !bus.i_busy && (eng_len == 0) && (eng_delay == 0);
    endfunction

    task automatic wait_quiet(input string tag, input int budget);
        int k = 0;
        while (!quiet() && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(quiet()), 32'd1);
    endtask

    task automatic wait_sweep_running(input string tag, input int budget);
        int k = 0;
        while (!(m_on && m_seen) && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(m_on && m_seen), 32'd1);
    endtask

    // One clock edge of the reference model, from the inputs seen at that edge
    task automatic model_step();
        bit          busy;
        bit          xfer;
        bit          wr_en;
        int          addr;
        int          code;
        logic [31:0] wd;
        logic [31:0] st;
        bit          fin;
        bit          tmo;
        busy  = bus.i_busy;
        xfer  = bus.i_wb_cyc && bus.i_wb_stb;
        wr_en = xfer && bus.i_wb_we;
        addr  = int'(bus.i_wb_addr);
        wd    = bus.i_wb_data;
        fin   = 0;
        tmo   = 0;
        if (!m_on)          code = 0;
        else if (m_age == 0) code = 1;
        else if (!m_seen)   code = 2;
        else                code = 3;
        st = {m_err, busy, 12'd0, 2'(code), 8'd0, 8'(m_pend)};

        exp_ack  = xfer;
        exp_data = '0;
        if (xfer && !wr_en) begin
            if (addr == 1)      exp_data = st;
            else if (addr == 2) exp_data = {16'd0, 16'(m_done)};
        end

        if (!m_on) begin
            if (m_pend != 0 && !busy) begin
                m_on = 1; m_age = 0; m_seen = 0; m_wait = 0;
            end
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (!m_seen) begin
            if (busy) m_seen = 1;
            else begin
                m_wait++;
                if (m_wait == 4) begin tmo = 1; m_on = 0; end
            end
        end else if (!busy) begin
            fin  = 1;
            m_on = 0;
        end

        if ((fin || tmo) && m_pend > 0) m_pend--;
        if (wr_en && addr == 0) begin
            if (wd[8]) m_pend = 0;
            else begin
                m_pend += int'(wd[7:0]);
                if (m_pend > 255) m_pend = 255;
            end
        end
        if (wr_en && addr == 2) m_done = 0;
        else if (fin)           m_done = (m_done + 1) % 65536;
        if (tmo)                       m_err = 1;
        else if (wr_en && addr == 1)   m_err = 0;

        exp_req = m_on && (m_age == 0);
        exp_irq = fin && (m_pend == 0);
    endtask

    // Reference model driver
    initial begin
        forever begin
            @(posedge i_clk or negedge i_reset_n);
            if (!i_reset_n) begin
                m_pend = 0; m_done = 0; m_err = 0; m_live = 0; m_on = 0;
                m_age = 0; m_seen = 0; m_wait = 0;
                exp_ack = 0; exp_req = 0; exp_irq = 0; exp_data = '0;
            end else if (!m_live) begin
                m_live = 1;
                exp_ack = 0; exp_req = 0; exp_irq = 0; exp_data = '0;
            end else begin
                model_step();
            end
        end
    end

    // Output monitor, away from the active edge
    initial begin
        forever begin
            @(negedge i_clk);
            chk("ack",   32'(bus.o_wb_ack),   32'(exp_ack));
            chk("req",   32'(bus.o_request),  32'(exp_req));
            chk("irq",   32'(bus.o_irq),      32'(exp_irq));
            chk("stall", 32'(bus.o_wb_stall), 32'd0);
            if (exp_ack) chk("rdata", bus.o_wb_data, exp_data);
            if (bus.o_request) n_req++;
            if (bus.o_irq)     n_irq++;
        end
    end

    // Shift engine: busy rises 1-2 cycles after a request and holds eng_hold cycles
    initial begin
        bus.i_busy = 1'b0;
        forever begin
            @(negedge i_clk);
            if (!i_reset_n) begin
                bus.i_busy = 1'b0;
                eng_delay  = 0;
                eng_len    = 0;
            end else if (eng_len > 0) begin
                eng_len--;
                if (eng_len == 0) bus.i_busy = 1'b0;
            end else if (eng_delay > 0) begin
                eng_delay--;
                if (eng_delay == 0) begin
                    bus.i_busy = 1'b1;
                    eng_len    = eng_hold;
                end
            end else if (bus.o_request && !eng_dead) begin
                eng_delay = (eng_fix_delay != 0) ? eng_fix_delay : int'($urandom_range(1, 2));
            end
        end
    end

    // Stimulus
    initial begin
        logic [31:0] d;
        logic [31:0] d0;
        int          r0;
        int          i0;
        int          k;
        bus.i_wb_cyc  = 1'b0;
        bus.i_wb_stb  = 1'b0;
        bus.i_wb_we   = 1'b0;
        bus.i_wb_addr = 2'd0;
        bus.i_wb_data = '0;

        repeat (3) tick();
        chk("rst_ack",   32'(bus.o_wb_ack),  32'd0);
        chk("rst_req",   32'(bus.o_request), 32'd0);
        chk("rst_irq",   32'(bus.o_irq),     32'd0);
        chk("rst_rdata", bus.o_wb_data,      32'd0);
        i_reset_n = 1'b1;
        tick();
        tick();
        rd(2'd1, d); chk("init_status", d, 32'd0);
        rd(2'd2, d); chk("init_done",   d, 32'd0);

        // Three queued sweeps with a 2-cycle start and 20-cycle busy engine
        eng_fix_delay = 2;
        eng_hold      = 20;
        r0 = n_req; i0 = n_irq;
        wr(2'd0, 32'd3);
        wait_quiet("s3_quiet", 300);
        chk("s3_reqs", 32'(n_req - r0), 32'd3);
        chk("s3_irqs", 32'(n_irq - i0), 32'd1);
        rd(2'd2, d); chk("s3_done",   d, 32'd3);
        rd(2'd1, d); chk("s3_status", d, 32'd0);

        // Saturating add
        wr(2'd0, 32'd250);
        wr(2'd0, 32'd10);
        rd(2'd1, d); chk("sat_pend", 32'(d[7:0]), 32'd255);
        wr(2'd0, 32'h100);
        wait_quiet("sat_quiet", 200);

        // Engine never starts: timeout sets error, drops one pending, no irq
        eng_dead = 1;
        i0 = n_irq;
        wr(2'd0, 32'd1);
        repeat (10) tick();
        rd(2'd1, d); chk("tmo_status", d, 32'h8000_0000);
        chk("tmo_noirq", 32'(n_irq - i0), 32'd0);
        wr(2'd1, 32'd0);
        rd(2'd1, d); chk("tmo_errclr", d, 32'd0);
        eng_dead = 0;

        // Clear while a sweep is running: it completes, then nothing more
        eng_hold = 30;
        rd(2'd2, d0);
        r0 = n_req; i0 = n_irq;
        wr(2'd0, 32'd5);
        wait_sweep_running("clr_run", 40);
        wr(2'd0, 32'h100);
        wait_quiet("clr_quiet", 100);
        rd(2'd1, d); chk("clr_status", d, 32'd0);
        rd(2'd2, d); chk("clr_done", d, d0 + 32'd1);
        chk("clr_reqs", 32'(n_req - r0), 32'd1);
        chk("clr_irqs", 32'(n_irq - i0), 32'd1);

        // Add landing on the completion edge with one pending
        eng_hold = 8;
        wr(2'd0, 32'd1);
        wait_sweep_running("coin_run", 40);
        k = 0;
        while (bus.i_busy && k < 40) begin
            tick();
            k++;
        end
        chk("coin_fall", 32'(bus.i_busy), 32'd0);
        i0 = n_irq;
        wr(2'd0, 32'd2);
        rd(2'd1, d); chk("coin_status", d, 32'd2);
        chk("coin_noirq", 32'(n_irq - i0), 32'd0);
        wait_quiet("coin_quiet", 200);

        // Reset in the middle of a sweep
        eng_hold = 30;
        wr(2'd0, 32'd4);
        wait_sweep_running("rst_run", 40);
        i_reset_n = 1'b0;
        tick();
        chk("mid_rst_req", 32'(bus.o_request), 32'd0);
        chk("mid_rst_irq", 32'(bus.o_irq),     32'd0);
        tick();
        i_reset_n = 1'b1;
        tick();
        tick();
        bus.i_wb_cyc  = 1'b1;
        bus.i_wb_stb  = 1'b1;
        bus.i_wb_we   = 1'b0;
        bus.i_wb_addr = 2'd1;
        tick();
        chk("post_rst_ack",    32'(bus.o_wb_ack), 32'd1);
        chk("post_rst_status", bus.o_wb_data,     32'd0);
        bus.i_wb_cyc = 1'b0;
        bus.i_wb_stb = 1'b0;
        rd(2'd2, d); chk("post_rst_done", d, 32'd0);

        // Random traffic, including back-to-back strobes and dead-engine spells
        eng_fix_delay = 0;
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if ($urandom_range(0, 199) == 0) eng_dead = !eng_dead;
            eng_hold = int'($urandom_range(1, 6));
            if (r < 40) begin
                bus.i_wb_cyc  = 1'b1;
                bus.i_wb_stb  = 1'b1;
                bus.i_wb_we   = 1'($urandom_range(0, 1));
                bus.i_wb_addr = 2'($urandom_range(0, 3));
                d = $urandom;
                if (bus.i_wb_addr == 2'd0) begin
                    d[8]   = ($urandom_range(0, 15) == 0);
                    d[7:0] = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                                         : 8'($urandom_range(0, 3));
                end
                bus.i_wb_data = d;
            end else begin
                bus.i_wb_cyc = 1'($urandom_range(0, 1));
                bus.i_wb_stb = 1'b0;
                bus.i_wb_we  = 1'b0;
            end
            tick();
        end
        bus.i_wb_cyc = 1'b0;
        bus.i_wb_stb = 1'b0;
        bus.i_wb_we  = 1'b0;
        eng_dead = 0;
        wr(2'd0, 32'h100);
        wait_quiet("rand_quiet", 300);
        rd(2'd1, d); chk("rand_pend", 32'(d[7:0]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
